mask_prefetch_server: RTL

- Responder side of the sampler's mask request interface (req_mask -> mask_out/mask_valid).
- Sits between drbg_system and the masked Gaussian sampler.
- Prefetches DRBG mask words into a small FIFO, so a sampler request is normally served 1 cycle after it is raised, not after DRBG latency.
- Flushes all stored masks when a reseed starts, so no pre-reseed randomness is consumed after a reseed.

---
 rtl/mask_prefetch_server_pkg.sv | 16 +
 rtl/mask_prefetch_server_if.sv | 26 ++
 rtl/mask_prefetch_server_fifo_zeroize.sv | 62 ++++++
 rtl/mask_prefetch_server.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mask_prefetch_server_pkg.sv
// Shared types and sizing helpers for the mask prefetch server.
package mask_srv_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } up_state_e;

  localparam int MASK_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mask_prefetch_server_if.sv
// Sampler-side and DRBG-side handshake signals of the mask prefetch server.
interface mask_prefetch_server_if
  import mask_srv_pkg::*;
#(
  parameter int MASK_WIDTH = MASK_WIDTH_DEF
);

  logic                  req_mask;
  logic [MASK_WIDTH-1:0] mask_out;
  logic                  mask_valid;
  logic                  drbg_gen_mask;
  logic [MASK_WIDTH-1:0] drbg_mask_in;
  logic                  drbg_mask_valid;
  logic                  drbg_reseeding;

  modport slave (
    input  req_mask, drbg_mask_in, drbg_mask_valid, drbg_reseeding,
    output mask_out, mask_valid, drbg_gen_mask
  );

  modport master (
    output req_mask, drbg_mask_in, drbg_mask_valid, drbg_reseeding,
    input  mask_out, mask_valid, drbg_gen_mask
  );

endinterface

// File: rtl/mask_prefetch_server_fifo_zeroize.sv
// Synchronous mask FIFO that zeroes each entry as it is popped and all entries on flush.
module mask_fifo_zeroize #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_pop,
  input  logic                 i_flush,
  output logic [WIDTH-1:0]     o_head,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_full;
  logic                 w_do_pop;
  logic                 w_do_push;

  assign w_full     = (r_count == CNT_WIDTH'(DEPTH));
  assign w_do_pop   = i_pop && (r_count != '0) && !i_flush;
  // A pop frees the slot the same cycle, so push into a full FIFO is legal then.
  assign w_do_push  = i_push && (!w_full || w_do_pop) && !i_flush;
  assign o_overflow = i_push && !i_flush && w_full && !w_do_pop;
  assign o_head     = r_mem[r_rptr];
  assign o_count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset too, so no mask word outlives a reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_pop) begin
        r_mem[r_rptr] <= '0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/mask_prefetch_server.sv
// Serves sampler mask requests from a prefetched DRBG word FIFO; flushes on reseed.
module mask_prefetch_server
  import mask_srv_pkg::*;
#(
  parameter int MASK_WIDTH = MASK_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = cnt_width(DEPTH),
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  mask_prefetch_server_if.slave bus,
  output logic [CNT_WIDTH-1:0] fill_level,
  output logic                 err
);

  localparam int TCNT_W = $clog2(TIMEOUT);

  up_state_e             r_state;
  logic [TCNT_W-1:0]     r_tcnt;
  logic                  r_req_q;
  logic                  r_dn_pend;
  logic                  r_mask_valid;
  logic [MASK_WIDTH-1:0] r_mask_out;
  logic                  r_gen_mask;
  logic                  r_err;

  logic                  w_flush;
  logic                  w_pend;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_overflow;
  logic [MASK_WIDTH-1:0] w_head;
  logic [CNT_WIDTH-1:0]  w_count;

  assign w_flush = bus.drbg_reseeding;
  // A fresh rising edge counts as pending this cycle, giving the 1-cycle hit latency.
  assign w_pend  = r_dn_pend | (bus.req_mask & ~r_req_q);
  assign w_pop   = w_pend && (w_count != '0) && !w_flush;
  assign w_push  = (r_state == WAIT) && bus.drbg_mask_valid && !w_flush;

  mask_fifo_zeroize #(
    .WIDTH    (MASK_WIDTH),
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (bus.drbg_mask_in),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_overflow(w_overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q      <= 1'b0;
      r_dn_pend    <= 1'b0;
      r_mask_valid <= 1'b0;
      r_mask_out   <= '0;
    end else begin
      r_req_q <= bus.req_mask;
      if (w_pop) begin
        r_mask_valid <= 1'b1;
        r_mask_out   <= w_head;
        r_dn_pend    <= 1'b0;
      end else begin
        r_mask_valid <= 1'b0;
        r_mask_out   <= '0;
        r_dn_pend    <= w_pend;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tcnt     <= '0;
      r_gen_mask <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_gen_mask <= 1'b0;
      if (w_overflow) r_err <= 1'b1;
      if (w_flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_count < CNT_WIDTH'(DEPTH)) begin
              r_gen_mask <= 1'b1;
              r_tcnt     <= '0;
              r_state    <= WAIT;
            end
          end
          WAIT: begin
            if (bus.drbg_mask_valid) begin
              r_state <= IDLE;
            end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mask_valid    = r_mask_valid;
  assign bus.mask_out      = r_mask_out;
  assign bus.drbg_gen_mask = r_gen_mask;
  assign fill_level        = w_count;
  assign err               = r_err;

endmodule
